// File: rtl/act_pkg.sv
// Shared types and sizing for the activation-unit arbiter.
package act_pkg;

   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned OUT_CH    = 16;
   localparam int unsigned BURST_MAX = 64;
   localparam int unsigned ACT_LAT   = 1;

   // Index width, kept at least 1 bit so a single-requester build still elaborates
   function automatic int unsigned req_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned REQ_ID_W = req_id_w(NUM_REQ);
   localparam int unsigned CNT_W    = $clog2(BURST_MAX + 1);

   typedef logic signed [DATA_W-1:0] chan_t;
   typedef chan_t [OUT_CH-1:0] vec_t;

   typedef struct packed {
      logic                valid;
      logic [REQ_ID_W-1:0] id;
      logic                last;
   } tag_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/act_arbiter_rr.sv
// Combinational round-robin pick: first set request searching upward from ptr+1 with wrap.
module rr_arbiter
   import act_pkg::*;
#(
   parameter int unsigned N = NUM_REQ
) (
   input  logic [N-1:0]             req,
   input  logic [req_id_w(N)-1:0]   ptr,
   output logic [req_id_w(N)-1:0]   winner,
   output logic                     any_req
);

   localparam int unsigned IDX_W = req_id_w(N);

   logic [IDX_W-1:0] idx;

   // Scan from farthest to nearest so the nearest hit after ptr is the one that sticks
   always_comb begin
      winner  = '0;
      idx     = '0;
      any_req = |req;
      for (int i = int'(N); i >= 1; i--) begin
         idx = IDX_W'((int'(ptr) + i) % int'(N));
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/act_arbiter.sv
// Shares one registered ReLU unit between NUM_REQ engines: burst round-robin grant,
// forward path to the unit, and tag pipe that routes results back to their owner.
module act_arbiter
   import act_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  req_valid,
   input  logic [NUM_REQ-1:0]  req_last,
   input  vec_t [NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]  req_ready,
   output vec_t                act_in_data,
   output logic                act_in_valid,
   input  vec_t                act_out_data,
   input  logic                act_out_valid,
   output logic [NUM_REQ-1:0]  rsp_valid,
   output vec_t                rsp_data,
   output logic                rsp_last,
   output logic [REQ_ID_W-1:0] grant_id,
   output logic                busy,
   output logic                err
);

   state_t              state_q, state_d;
   logic [REQ_ID_W-1:0] gid_q, gid_d;
   logic [REQ_ID_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q;
   tag_t                tag_q [ACT_LAT];
   tag_t                tag_in;
   tag_t                tag_out;
   logic                xfer;
   logic                eob;
   logic [REQ_ID_W-1:0] winner;
   logic                any_req;
   logic                tag_busy;
   logic                hit;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gid_q   <= '0;
         ptr_q   <= REQ_ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: arbitrate in IDLE (bubble cycle), stream beats in BURST
   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      xfer    = 1'b0;
      eob     = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gid_d   = winner;
               ptr_d   = winner;
               state_d = BURST;
            end
         end
         BURST: begin
            xfer = req_valid[gid_q];
            if (xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (req_last[gid_q] || (cnt_q == CNT_W'(BURST_MAX - 1))) begin
                  eob     = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tag_in = '{valid: xfer, id: gid_q, last: eob};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ACT_LAT); i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < int'(ACT_LAT); i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_out = tag_q[ACT_LAT-1];

   // Any disagreement between the unit's valid and the tag is sticky until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (act_out_valid != tag_out.valid) begin
         err_q <= 1'b1;
      end
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i < int'(ACT_LAT); i++) begin
         tag_busy = tag_busy | tag_q[i].valid;
      end
   end

   // Forward and return paths are pure decode of registered state plus live inputs
   always_comb begin
      req_ready = '0;
      if (state_q == BURST) begin
         req_ready[gid_q] = 1'b1;
      end
      act_in_valid = xfer;
      act_in_data  = xfer ? req_data[gid_q] : '0;
      hit          = act_out_valid & tag_out.valid;
      rsp_valid    = '0;
      if (hit) begin
         rsp_valid[tag_out.id] = 1'b1;
      end
      rsp_data = hit ? act_out_data : '0;
      rsp_last = hit & tag_out.last;
   end

   assign grant_id = gid_q;
   assign busy     = (state_q == BURST) | tag_busy;
   assign err      = err_q;

endmodule

// File: tb/tb_act_arbiter.sv
// Directed bench for act_arbiter with a registered ReLU model standing in for the activation unit.
module tb_act_arbiter;
   import act_pkg::*;

   logic                clk;
   logic                rst;
   logic [NUM_REQ-1:0]  req_valid;
   logic [NUM_REQ-1:0]  req_last;
   vec_t [NUM_REQ-1:0]  req_data;
   logic [NUM_REQ-1:0]  req_ready;
   vec_t                act_in_data;
   logic                act_in_valid;
   vec_t                act_out_data;
   logic                act_out_valid;
   logic [NUM_REQ-1:0]  rsp_valid;
   vec_t                rsp_data;
   logic                rsp_last;
   logic [REQ_ID_W-1:0] grant_id;
   logic                busy;
   logic                err;

   logic act_v;
   vec_t act_q;
   logic inj;

   int total = 0;
   int bad   = 0;

   act_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .act_in_data   (act_in_data),
      .act_in_valid  (act_in_valid),
      .act_out_data  (act_out_data),
      .act_out_valid (act_out_valid),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_last      (rsp_last),
      .grant_id      (grant_id),
      .busy          (busy),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t relu(input vec_t v);
      vec_t r;
      for (int k = 0; k < int'(OUT_CH); k++) begin
         r[k] = v[k][DATA_W-1] ? '0 : v[k];
      end
      return r;
   endfunction

   function automatic vec_t mkvec(input int b);
      vec_t v;
      v[0] = DATA_W'(-5);
      v[1] = DATA_W'(7);
      for (int k = 2; k < int'(OUT_CH); k++) begin
         v[k] = DATA_W'(b + k);
      end
      return v;
   endfunction

   // Activation unit: one register stage, inj forces a spurious valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_v <= 1'b0;
         act_q <= '0;
      end else begin
         act_v <= act_in_valid;
         act_q <= relu(act_in_data);
      end
   end
   assign act_out_valid = act_v | inj;
   assign act_out_data  = act_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      inj       = 1'b0;
      nxt();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin : main
      int          sent [NUM_REQ];
      int          q [$];
      int          gaps [$];
      int          gap;
      int          exp2 [5];
      logic [NUM_REQ-1:0] prev;
      int          sent2, rsp2, first_last, lasts2, rsp0;
      logic        done0;
      logic        v0, v2;

      rst       = 1'b1;
      inj       = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_ain", 32'(act_in_valid), 0);
      chk("rst_rsp", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_gid", 32'(grant_id), 0);

      // Single engine 1, 3-beat burst
      do_reset();
      req_valid   = 4'b0010;
      req_data[1] = mkvec(0);
      @(negedge clk);
      chk("t1_bub_ready", 32'(req_ready), 0);
      chk("t1_bub_ain", 32'(act_in_valid), 0);
      nxt();
      @(negedge clk);
      chk("t1_b0_ready", 32'(req_ready), 32'h2);
      chk("t1_b0_ain", 32'(act_in_valid), 1);
      chk("t1_b0_gid", 32'(grant_id), 1);
      chk("t1_b0_d0", {act_in_data[0]}, 32'hFB);
      chk("t1_b0_busy", 32'(busy), 1);
      chk("t1_b0_rsp", 32'(rsp_valid), 0);
      nxt();
      req_data[1] = mkvec(1);
      @(negedge clk);
      chk("t1_r0_rsp", 32'(rsp_valid), 32'h2);
      chk("t1_r0_d0", {rsp_data[0]}, 0);
      chk("t1_r0_d1", {rsp_data[1]}, 7);
      chk("t1_r0_d2", {rsp_data[2]}, 2);
      chk("t1_r0_last", 32'(rsp_last), 0);
      nxt();
      req_data[1] = mkvec(2);
      req_last[1] = 1'b1;
      @(negedge clk);
      chk("t1_r1_d2", {rsp_data[2]}, 3);
      chk("t1_r1_last", 32'(rsp_last), 0);
      chk("t1_b2_ain", 32'(act_in_valid), 1);
      nxt();
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      chk("t1_r2_rsp", 32'(rsp_valid), 32'h2);
      chk("t1_r2_last", 32'(rsp_last), 1);
      chk("t1_r2_d2", {rsp_data[2]}, 4);
      chk("t1_r2_ain", 32'(act_in_valid), 0);
      chk("t1_r2_busy", 32'(busy), 1);
      nxt();
      @(negedge clk);
      chk("t1_end_busy", 32'(busy), 0);
      chk("t1_end_rsp", 32'(rsp_valid), 0);

      // All engines valid, 2-beat bursts: order 0,1,2,3,0 with one bubble each
      do_reset();
      exp2 = '{0, 1, 2, 3, 0};
      for (int e = 0; e < int'(NUM_REQ); e++) sent[e] = 0;
      gap  = 0;
      prev = '0;
      req_valid = 4'hF;
      for (int c = 0; c < 14; c++) begin
         for (int e = 0; e < int'(NUM_REQ); e++) begin
            req_data[e] = mkvec(e * 10 + sent[e]);
            req_last[e] = (sent[e] % 2 == 1);
         end
         @(negedge clk);
         if (req_ready == '0) begin
            gap++;
         end else if (prev == '0) begin
            q.push_back(int'(grant_id));
            gaps.push_back(gap);
            gap = 0;
         end
         for (int e = 0; e < int'(NUM_REQ); e++) begin
            if (req_ready[e] && req_valid[e]) sent[e]++;
         end
         prev = req_ready;
         nxt();
      end
      chk("t2_ngrant", 32'(q.size()), 5);
      for (int i = 0; i < q.size() && i < 5; i++) begin
         chk($sformatf("t2_gnt%0d", i), 32'(q[i]), 32'(exp2[i]));
         chk($sformatf("t2_gap%0d", i), 32'(gaps[i]), 1);
      end

      // Engine 2 streams 100 beats without last; forced end at 64, engine 0 cuts in
      do_reset();
      q.delete();
      sent2 = 0; rsp2 = 0; first_last = 0; lasts2 = 0; rsp0 = 0;
      done0 = 1'b0;
      prev  = '0;
      for (int c = 0; c < 115; c++) begin
         v2 = (sent2 < 100);
         v0 = (c >= 10) && !done0;
         req_valid   = {1'b0, v2, 1'b0, v0};
         req_last    = 4'b0001;
         req_data[2] = mkvec(sent2);
         req_data[0] = mkvec(50);
         @(negedge clk);
         if (req_ready != '0 && prev == '0) q.push_back(int'(grant_id));
         if (req_ready[2] && v2) sent2++;
         if (req_ready[0] && v0) done0 = 1'b1;
         if (rsp_valid[2]) begin
            rsp2++;
            if (rsp_last) begin
               lasts2++;
               if (first_last == 0) first_last = rsp2;
            end
         end
         if (rsp_valid[0] && rsp_last) rsp0++;
         prev = req_ready;
         nxt();
      end
      chk("t3_ngrant", 32'(q.size()), 3);
      if (q.size() >= 3) begin
         chk("t3_gnt0", 32'(q[0]), 2);
         chk("t3_gnt1", 32'(q[1]), 0);
         chk("t3_gnt2", 32'(q[2]), 2);
      end
      chk("t3_forced_at", 32'(first_last), 64);
      chk("t3_nlast2", 32'(lasts2), 1);
      chk("t3_rsp2", 32'(rsp2), 100);
      chk("t3_rsp0", 32'(rsp0), 1);

      // Engine 3 gap of 5 cycles mid-burst while engine 1 waits
      do_reset();
      req_data[3] = mkvec(30);
      req_data[1] = mkvec(40);
      for (int c = 0; c < 11; c++) begin
         req_valid[3] = (c <= 2) || (c == 8);
         req_last[3]  = (c == 8);
         req_valid[1] = (c >= 3);
         req_last[1]  = 1'b1;
         @(negedge clk);
         if (c >= 3 && c <= 7) begin
            chk($sformatf("t4_gap%0d_ready", c), 32'(req_ready), 32'h8);
            chk($sformatf("t4_gap%0d_ain", c), 32'(act_in_valid), 0);
         end
         if (c == 8) chk("t4_resume_ain", 32'(act_in_valid), 1);
         if (c == 10) begin
            chk("t4_next_gid", 32'(grant_id), 1);
            chk("t4_next_ready", 32'(req_ready), 32'h2);
         end
         nxt();
      end

      // Spurious act_out_valid with empty tag pipe
      do_reset();
      inj = 1'b1;
      @(negedge clk);
      chk("t5_rsp", 32'(rsp_valid), 0);
      chk("t5_err_pre", 32'(err), 0);
      nxt();
      inj = 1'b0;
      @(negedge clk);
      chk("t5_err_set", 32'(err), 1);
      repeat (4) nxt();
      @(negedge clk);
      chk("t5_err_sticky", 32'(err), 1);
      do_reset();
      @(negedge clk);
      chk("t5_err_clr", 32'(err), 0);

      // Reset asserted during beat 2 of an engine-1 burst
      do_reset();
      req_valid   = 4'b0010;
      req_data[1] = mkvec(60);
      nxt();
      nxt();
      nxt();
      chk("t6_pre_rsp", 32'(rsp_valid), 32'h2);
      rst = 1'b1;
      #1;
      chk("t6_ready", 32'(req_ready), 0);
      chk("t6_ain", 32'(act_in_valid), 0);
      chk("t6_aind", {act_in_data[2]}, 0);
      chk("t6_rsp", 32'(rsp_valid), 0);
      chk("t6_last", 32'(rsp_last), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_gid", 32'(grant_id), 0);
      chk("t6_err", 32'(err), 0);
      nxt();
      rst       = 1'b0;
      req_valid = 4'b0101;
      req_last  = 4'b0101;
      @(negedge clk);
      chk("t6_post_rsp", 32'(rsp_valid), 0);
      nxt();
      @(negedge clk);
      chk("t6_post_gid", 32'(grant_id), 0);
      chk("t6_post_err", 32'(err), 0);
      req_valid = '0;
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
